// File: rtl/audio_send_pkg.sv
// Shared audio constants for the WM8978 DAC transmit and ADC capture paths.
// Holds the word length, channel encoding and FIFO sizing.
package audio_send_pkg;

    localparam logic [5:0] WL_DEF      = 6'd32;
    localparam int         SAMPLE_W    = 32;
    localparam int         FIFO_AW_DEF = 2;
    localparam int         FIFO_DEPTH  = 2 ** FIFO_AW_DEF;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    // Shift-register bit carrying serial bit 'cnt' (0 = MSB) of a WL-bit word.
    function automatic logic [4:0] bit_index(input logic [5:0] wl, input logic [5:0] cnt);
        return 5'(wl - 6'd1 - cnt);
    endfunction

endpackage

// File: rtl/audio_send_fifo.sv
// Synchronous sample FIFO: push/pop with an occupancy count. Push is ignored
// when full and pop is ignored when empty.
module sample_fifo #(
    parameter int DW = 32,
    parameter int AW = 2
) (
    input  logic          aud_bclk,
    input  logic          sys_rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: the read side only uses entries covered by level.
    always_ff @(posedge aud_bclk)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge aud_bclk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/audio_send.sv
// I2S transmit serializer for the WM8978 DAC in slave-clock mode: queues user
// words and shifts one out MSB-first per LRC half-frame, one BCLK after the edge.
module audio_send
    import audio_send_pkg::*;
#(
    parameter logic [5:0] WL      = WL_DEF,
    parameter int         FIFO_AW = FIFO_AW_DEF
) (
    input  logic                aud_bclk,
    input  logic                sys_rst,
    input  logic                aud_lrc,
    input  logic [SAMPLE_W-1:0] dac_data,
    input  logic                dac_valid,
    output logic                dac_ready,
    output logic                aud_dacdat,
    output logic                tx_done,
    output logic                underrun,
    output logic [FIFO_AW:0]    fifo_level
);

    logic                lrc_d0, lrc_edge;
    logic                fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head, shreg;
    logic [5:0]          tx_cnt;

    assign lrc_edge  = aud_lrc ^ lrc_d0;
    assign dac_ready = !fifo_full;

    sample_fifo #(
        .DW (SAMPLE_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .aud_bclk (aud_bclk),
        .sys_rst  (sys_rst),
        .push     (dac_valid),
        .pop      (lrc_edge),
        .din      (dac_data),
        .dout     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // tx_cnt == WL means idle; an LRC edge always restarts the word, so a
    // late word is abandoned rather than finished.
    always_ff @(posedge aud_bclk or negedge sys_rst) begin
        if (!sys_rst) begin
            lrc_d0   <= 1'b0;
            shreg    <= '0;
            tx_cnt   <= WL;
            tx_done  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            lrc_d0   <= aud_lrc;
            tx_done  <= (tx_cnt == WL - 6'd1);
            underrun <= lrc_edge && fifo_empty;
            if (lrc_edge) begin
                shreg  <= fifo_empty ? '0 : fifo_head;
                tx_cnt <= 6'd0;
            end else if (tx_cnt < WL) begin
                tx_cnt <= tx_cnt + 6'd1;
            end
        end
    end

    // Negedge launch gives the codec a full half-cycle of setup before its posedge.
    always_ff @(negedge aud_bclk or negedge sys_rst) begin
        if (!sys_rst)
            aud_dacdat <= 1'b0;
        else
            aud_dacdat <= (tx_cnt < WL) ? shreg[bit_index(WL, tx_cnt)] : 1'b0;
    end

endmodule

// File: tb/tb_audio_send.sv
// Self-checking bench for audio_send: WL=32 and WL=16 instances share stimulus
// and are compared each cycle against a queue-based I2S frame model.
module tb_audio_send;

    logic        aud_bclk = 1'b0;
    logic        sys_rst, aud_lrc, dac_valid;
    logic [31:0] dac_data;
    logic        dac_ready, aud_dacdat, tx_done, underrun;
    logic [2:0]  fifo_level;
    logic        dac_ready16, aud_dacdat16, tx_done16, underrun16;
    logic [2:0]  fifo_level16;

    int checks = 0, failures = 0, cyc = 0;

    // model state
    bit          prev_lrc, lrc_now;
    logic [31:0] model_q[$];
    bit          str32[$], str16[$];
    int          done_at32 = -1, done_at16 = -1;
    bit          exp_dat32, exp_dat16, exp_done32, exp_done16, exp_und;

    always #5 aud_bclk = ~aud_bclk;

    audio_send #(.WL(6'd32)) dut (
        .aud_bclk(aud_bclk), .sys_rst(sys_rst), .aud_lrc(aud_lrc),
        .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .aud_dacdat(aud_dacdat), .tx_done(tx_done), .underrun(underrun),
        .fifo_level(fifo_level)
    );

    audio_send #(.WL(6'd16)) dut16 (
        .aud_bclk(aud_bclk), .sys_rst(sys_rst), .aud_lrc(aud_lrc),
        .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready16),
        .aud_dacdat(aud_dacdat16), .tx_done(tx_done16), .underrun(underrun16),
        .fifo_level(fifo_level16)
    );

    task automatic model_reset();
        model_q.delete();
        str32.delete();
        str16.delete();
        done_at32 = -1;
        done_at16 = -1;
        prev_lrc  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance one bclk, then predict outputs.
    task automatic step(input bit lrc, input bit vld, input logic [31:0] d);
        bit          edge_seen, acc;
        logic [31:0] w;
        aud_lrc = lrc; dac_valid = vld; dac_data = d;
        @(negedge aud_bclk); #1;
        cyc++;
        edge_seen  = (lrc != prev_lrc);
        prev_lrc   = lrc;
        acc        = vld && (model_q.size() < 4);
        exp_done32 = (cyc == done_at32);
        exp_done16 = (cyc == done_at16);
        exp_und    = 1'b0;
        if (edge_seen) begin
            w = '0;
            if (model_q.size() > 0) w = model_q.pop_front();
            else exp_und = 1'b1;
            str32.delete();
            str16.delete();
            for (int i = 31; i >= 0; i--) str32.push_back(w[i]);
            for (int i = 15; i >= 0; i--) str16.push_back(w[i]);
            done_at32 = cyc + 32;
            done_at16 = cyc + 16;
        end
        if (acc) model_q.push_back(d);
        exp_dat32 = (str32.size() > 0) ? str32.pop_front() : 1'b0;
        exp_dat16 = (str16.size() > 0) ? str16.pop_front() : 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; aud_lrc = 1'b0; dac_valid = 1'b0; dac_data = '0;
        repeat (3) @(negedge aud_bclk);
        #1;
        checks++; if (aud_dacdat !== 1'b0) begin failures++; $display("FAIL rst_dacdat got=%b exp=0", aud_dacdat); end
        checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL rst_tx_done got=%b exp=0", tx_done); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        checks++; if (dac_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", dac_ready); end
        checks++; if (aud_dacdat16 !== 1'b0 || tx_done16 !== 1'b0) begin failures++; $display("FAIL rst_wl16 got=%b%b exp=00", aud_dacdat16, tx_done16); end
        sys_rst = 1'b1;
        model_reset();
        lrc_now = 1'b0;
        repeat (2) step(lrc_now, 1'b0, '0);
    endtask

    task automatic test_i2s();
        int n_done = 0, n_und = 0;
        step(lrc_now, 1'b1, 32'hA5A5_0F0F);
        step(lrc_now, 1'b1, 32'h1234_5678);
        checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL i2s_level got=%0d exp=2", fifo_level); end
        for (int f = 0; f < 2; f++) begin
            lrc_now = ~lrc_now;
            for (int n = 0; n < 32 + f; n++) begin
                step(lrc_now, 1'b0, '0);
                n_done += tx_done; n_und += underrun;
                checks++; if (aud_dacdat !== exp_dat32) begin failures++; $display("FAIL i2s_bit cyc=%0d got=%b exp=%b", cyc, aud_dacdat, exp_dat32); end
                checks++; if (tx_done !== exp_done32) begin failures++; $display("FAIL i2s_done cyc=%0d got=%b exp=%b", cyc, tx_done, exp_done32); end
                checks++; if (aud_dacdat16 !== exp_dat16 || tx_done16 !== exp_done16) begin failures++; $display("FAIL i2s_wl16 cyc=%0d got=%b%b exp=%b%b", cyc, aud_dacdat16, tx_done16, exp_dat16, exp_done16); end
            end
        end
        checks++; if (n_done != 2) begin failures++; $display("FAIL i2s_done_count got=%0d exp=2", n_done); end
        checks++; if (n_und != 0) begin failures++; $display("FAIL i2s_underrun_count got=%0d exp=0", n_und); end
    endtask

    task automatic test_underrun();
        lrc_now = ~lrc_now;
        step(lrc_now, 1'b1, 32'hC3C3_8001);
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL und_pulse got=%b exp=1", underrun); end
        checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL und_level got=%0d exp=1", fifo_level); end
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 33; n++) begin
                if (n > 0 || f > 0) step(lrc_now, 1'b0, '0);
                checks++; if (aud_dacdat !== exp_dat32) begin failures++; $display("FAIL und_bit cyc=%0d got=%b exp=%b", cyc, aud_dacdat, exp_dat32); end
                checks++; if (underrun !== exp_und || tx_done !== exp_done32) begin failures++; $display("FAIL und_flags cyc=%0d got=%b%b exp=%b%b", cyc, underrun, tx_done, exp_und, exp_done32); end
                checks++; if (aud_dacdat16 !== exp_dat16 || tx_done16 !== exp_done16) begin failures++; $display("FAIL und_wl16 cyc=%0d got=%b%b exp=%b%b", cyc, aud_dacdat16, tx_done16, exp_dat16, exp_done16); end
            end
            lrc_now = ~lrc_now;
        end
        lrc_now = ~lrc_now;
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            step(lrc_now, 1'b1, $urandom);
            checks++; if (fifo_level !== 3'(model_q.size())) begin failures++; $display("FAIL full_level i=%0d got=%0d exp=%0d", i, fifo_level, model_q.size()); end
            checks++; if (dac_ready !== (model_q.size() != 4)) begin failures++; $display("FAIL full_ready i=%0d got=%b exp=%b", i, dac_ready, model_q.size() != 4); end
        end
        checks++; if (dac_ready !== 1'b0 || fifo_level !== 3'd4) begin failures++; $display("FAIL full_5th got=%b/%0d exp=0/4", dac_ready, fifo_level); end
        lrc_now = ~lrc_now;
        step(lrc_now, 1'b1, 32'hDEAD_BEEF);
        checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL full_pop_write got=%0d exp=3", fifo_level); end
        for (int f = 0; f < 4; f++) begin
            for (int n = 0; n < 32; n++) begin
                if (n > 0 || f > 0) step(lrc_now, 1'b0, '0);
                checks++; if (aud_dacdat !== exp_dat32 || tx_done !== exp_done32 || underrun !== exp_und) begin failures++; $display("FAIL full_drain cyc=%0d got=%b%b%b exp=%b%b%b", cyc, aud_dacdat, tx_done, underrun, exp_dat32, exp_done32, exp_und); end
                checks++; if (aud_dacdat16 !== exp_dat16 || tx_done16 !== exp_done16) begin failures++; $display("FAIL full_wl16 cyc=%0d got=%b%b exp=%b%b", cyc, aud_dacdat16, tx_done16, exp_dat16, exp_done16); end
            end
            lrc_now = ~lrc_now;
        end
        lrc_now = ~lrc_now;
    endtask

    task automatic test_abort();
        int n_done = 0;
        step(lrc_now, 1'b1, 32'hF00F_1234);
        step(lrc_now, 1'b1, 32'h8765_4321);
        lrc_now = ~lrc_now;
        for (int n = 0; n < 11; n++) begin
            if (n == 10) lrc_now = ~lrc_now;
            step(lrc_now, 1'b0, '0);
            n_done += tx_done + tx_done16;
            checks++; if (aud_dacdat !== exp_dat32 || aud_dacdat16 !== exp_dat16) begin failures++; $display("FAIL abort_bit cyc=%0d got=%b%b exp=%b%b", cyc, aud_dacdat, aud_dacdat16, exp_dat32, exp_dat16); end
        end
        checks++; if (n_done != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
        checks++; if (aud_dacdat !== 1'b1) begin failures++; $display("FAIL abort_restart_msb got=%b exp=1", aud_dacdat); end
        for (int n = 0; n < 33; n++) begin
            step(lrc_now, 1'b0, '0);
            checks++; if (aud_dacdat !== exp_dat32 || tx_done !== exp_done32) begin failures++; $display("FAIL abort_next cyc=%0d got=%b%b exp=%b%b", cyc, aud_dacdat, tx_done, exp_dat32, exp_done32); end
            checks++; if (aud_dacdat16 !== exp_dat16 || tx_done16 !== exp_done16) begin failures++; $display("FAIL abort_wl16 cyc=%0d got=%b%b exp=%b%b", cyc, aud_dacdat16, tx_done16, exp_dat16, exp_done16); end
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        for (int i = 0; i < 4; i++) step(lrc_now, 1'b1, 32'hFFFF_FFFF);
        lrc_now = ~lrc_now;
        for (int n = 0; n < 5; n++) step(lrc_now, 1'b0, '0);
        sys_rst = 1'b0;
        #1;
        checks++; if (aud_dacdat !== 1'b0) begin failures++; $display("FAIL midrst_dacdat got=%b exp=0", aud_dacdat); end
        checks++; if (fifo_level !== 3'd0 || dac_ready !== 1'b1) begin failures++; $display("FAIL midrst_fifo got=%0d/%b exp=0/1", fifo_level, dac_ready); end
        @(negedge aud_bclk); #1;
        sys_rst = 1'b1;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            step(lrc_now, 1'b0, '0);
            n_done += tx_done;
            checks++; if (aud_dacdat !== exp_dat32 || underrun !== exp_und) begin failures++; $display("FAIL midrst_idle cyc=%0d got=%b%b exp=%b%b", cyc, aud_dacdat, underrun, exp_dat32, exp_und); end
        end
        step(lrc_now, 1'b1, 32'h0123_ABCD);
        lrc_now = ~lrc_now;
        for (int n = 0; n < 33; n++) begin
            step(lrc_now, 1'b0, '0);
            n_done += tx_done;
            checks++; if (aud_dacdat !== exp_dat32 || tx_done !== exp_done32) begin failures++; $display("FAIL midrst_word cyc=%0d got=%b%b exp=%b%b", cyc, aud_dacdat, tx_done, exp_dat32, exp_done32); end
        end
        checks++; if (n_done != 1) begin failures++; $display("FAIL midrst_done_count got=%0d exp=1", n_done); end
    endtask

    task automatic test_random();
        int left = 0;
        for (int n = 0; n < 800; n++) begin
            if (left == 0) begin
                lrc_now = ~lrc_now;
                left = ($urandom_range(0, 2) == 0) ? 32 : $urandom_range(6, 40);
            end
            left--;
            step(lrc_now, ($urandom_range(0, 9) < 4), $urandom);
            checks++; if (aud_dacdat !== exp_dat32 || tx_done !== exp_done32 || underrun !== exp_und) begin failures++; $display("FAIL rand32 cyc=%0d got=%b%b%b exp=%b%b%b", cyc, aud_dacdat, tx_done, underrun, exp_dat32, exp_done32, exp_und); end
            checks++; if (aud_dacdat16 !== exp_dat16 || tx_done16 !== exp_done16) begin failures++; $display("FAIL rand16 cyc=%0d got=%b%b exp=%b%b", cyc, aud_dacdat16, tx_done16, exp_dat16, exp_done16); end
            checks++; if (fifo_level !== 3'(model_q.size()) || dac_ready !== (model_q.size() != 4)) begin failures++; $display("FAIL rand_fifo cyc=%0d got=%0d/%b exp=%0d", cyc, fifo_level, dac_ready, model_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_i2s();
        test_underrun();
        test_full();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
